// File: rtl/cordic_stage.sv
// One registered CORDIC micro-rotation (iteration SHIFT) with a valid/ready output register.
// The add/subtract paths use 4-bit carry-lookahead slices with a ripple carry between slices.

module cordic_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c    = '0;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c[3:0];
    cout = c[4];
  end
endmodule

module cordic_addsub #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum
);
  localparam int unsigned NSLICE = WIDTH / 4;

  logic [WIDTH-1:0] b_eff;
  logic [NSLICE:0]  carry;
  logic             unused_cout;

  // Subtraction is a + ~b + 1: invert the operand and seed the chain with 1.
  assign b_eff       = b ^ {WIDTH{sub}};
  assign carry[0]    = sub;
  assign unused_cout = carry[NSLICE];

  for (genvar s = 0; s < NSLICE; s++) begin : g_slice
    cordic_cla4 u_cla4 (
      .a    (a[4*s +: 4]),
      .b    (b_eff[4*s +: 4]),
      .cin  (carry[s]),
      .sum  (sum[4*s +: 4]),
      .cout (carry[s+1])
    );
  end
endmodule

module cordic_stage #(
  parameter int unsigned      WIDTH = 16,
  parameter int unsigned      SHIFT = 0,
  parameter logic [WIDTH-1:0] ANGLE = 16'h2000,
  parameter bit               MODE  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] z_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic [WIDTH-1:0] z_out
);
  logic [WIDTH-1:0] xs;
  logic [WIDTH-1:0] ys;
  logic             d_pos;
  logic [WIDTH-1:0] x_next;
  logic [WIDTH-1:0] y_next;
  logic [WIDTH-1:0] z_next;

  always_comb begin
    xs    = $signed(x_in) >>> SHIFT;
    ys    = $signed(y_in) >>> SHIFT;
    d_pos = MODE ? y_in[WIDTH-1] : ~z_in[WIDTH-1];
  end

  // d=+1: x - ys, y + xs, z - ANGLE; d=-1 flips every operation.
  cordic_addsub #(.WIDTH(WIDTH)) u_add_x (
    .a   (x_in),
    .b   (ys),
    .sub (d_pos),
    .sum (x_next)
  );

  cordic_addsub #(.WIDTH(WIDTH)) u_add_y (
    .a   (y_in),
    .b   (xs),
    .sub (~d_pos),
    .sum (y_next)
  );

  cordic_addsub #(.WIDTH(WIDTH)) u_add_z (
    .a   (z_in),
    .b   (ANGLE),
    .sub (d_pos),
    .sum (z_next)
  );

  assign in_ready = ~out_valid | out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      z_out     <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      x_out     <= x_next;
      y_out     <= y_next;
      z_out     <= z_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cordic_stage.sv
// Bench for cordic_stage: several parameterisations share one input stream and are
// checked cycle by cycle against an integer-arithmetic reference and a one-deep scoreboard.

module tb_cordic_stage;
  localparam int unsigned NI = 5;
  localparam int unsigned        SH [NI] = '{0, 2, 0, 15, 7};
  localparam bit                 MD [NI] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic [15:0]        AN [NI] = '{16'h2000, 16'h2000, 16'h2000, 16'h0001, 16'h0146};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv = 1'b0;
  logic        ordy = 1'b0;
  logic [15:0] xi = '0;
  logic [15:0] yi = '0;
  logic [15:0] zi = '0;

  logic        ir [NI];
  logic        ov [NI];
  logic [15:0] xo [NI];
  logic [15:0] yo [NI];
  logic [15:0] zo [NI];

  logic [47:0] q [NI][$];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    cordic_stage #(
      .WIDTH (16),
      .SHIFT (SH[g]),
      .ANGLE (AN[g]),
      .MODE  (MD[g])
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv),
      .in_ready  (ir[g]),
      .x_in      (xi),
      .y_in      (yi),
      .z_in      (zi),
      .out_valid (ov[g]),
      .out_ready (ordy),
      .x_out     (xo[g]),
      .y_out     (yo[g]),
      .z_out     (zo[g])
    );
  end

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Micro-rotation computed with plain signed integers, truncated to 16 bits.
  function automatic logic [47:0] model(input int k, input logic [15:0] x, input logic [15:0] y,
                                        input logic [15:0] z);
    int xv, yv, zv, xsh, ysh, d, xn, yn, zn;
    xv  = int'($signed(x));
    yv  = int'($signed(y));
    zv  = int'($signed(z));
    xsh = xv >>> SH[k];
    ysh = yv >>> SH[k];
    if (MD[k]) d = y[15] ? 1 : -1;
    else       d = z[15] ? -1 : 1;
    xn = xv - d * ysh;
    yn = yv + d * xsh;
    zn = zv - d * int'($signed(AN[k]));
    return {16'(xn), 16'(yn), 16'(zn)};
  endfunction

  // Called just after a falling edge; drives one cycle and scores it.
  task automatic apply(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                       input logic v, input logic r);
    logic exp_v, exp_r;
    xi = x; yi = y; zi = z; iv = v; ordy = r;
    #1;
    for (int k = 0; k < int'(NI); k++) begin
      exp_v = (q[k].size() != 0);
      exp_r = !exp_v || r;
      check($sformatf("out_valid[%0d]", k), 48'(ov[k]), 48'(exp_v));
      check($sformatf("in_ready[%0d]", k), 48'(ir[k]), 48'(exp_r));
      if (exp_v) begin
        check($sformatf("data[%0d]", k), {xo[k], yo[k], zo[k]}, q[k][0]);
        if (r) void'(q[k].pop_front());
      end
      if (v && exp_r) q[k].push_back(model(k, x, y, z));
    end
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < int'(NI); k++) begin
      check($sformatf("%s_valid[%0d]", tag, k), 48'(ov[k]), 48'd0);
      check($sformatf("%s_data[%0d]", tag, k), {xo[k], yo[k], zo[k]}, 48'd0);
    end
  endtask

  initial begin
    logic [15:0] rx, ry, rz;
    repeat (2) @(negedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors from the worked examples.
    apply(16'h1000, 16'h0000, 16'h1000, 1'b1, 1'b1);
    check("tp_rot0", {xo[0], yo[0], zo[0]}, {16'h1000, 16'h1000, 16'hF000});
    apply(16'h1000, 16'h0400, 16'hE000, 1'b1, 1'b1);
    check("tp_rot2", {xo[1], yo[1], zo[1]}, {16'h1100, 16'h0000, 16'h0000});
    apply(16'h2000, 16'hF000, 16'h0000, 1'b1, 1'b1);
    check("tp_vec0", {xo[2], yo[2], zo[2]}, {16'h3000, 16'h1000, 16'hE000});
    apply(16'h7FFF, 16'h7FFF, 16'h0000, 1'b1, 1'b1);
    check("tp_wrap", {xo[0], yo[0], zo[0]}, {16'h0000, 16'hFFFE, 16'hE000});
    apply(16'h8000, 16'h8000, 16'h8000, 1'b1, 1'b1);
    apply('0, '0, '0, 1'b0, 1'b1);
    check("drain_valid", 48'(ov[0]), 48'd0);

    // Backpressure: 4 samples, 3-cycle stall mid-stream with changing upstream data.
    apply(16'h0123, 16'h0456, 16'h0789, 1'b1, 1'b1);
    apply(16'hF123, 16'h1456, 16'h9789, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      apply(16'($urandom), 16'($urandom), 16'($urandom), 1'b1, 1'b0);
      check("stall_in_ready", 48'(ir[0]), 48'd0);
    end
    apply(16'h3333, 16'hC444, 16'h5555, 1'b1, 1'b1);
    apply(16'hABCD, 16'h1234, 16'hFEDC, 1'b1, 1'b1);
    apply('0, '0, '0, 1'b0, 1'b1);

    // Random traffic with random backpressure and occasional extreme operands.
    for (int n = 0; n < 600; n++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      rz = 16'($urandom);
      if ($urandom_range(0, 7) == 0) rx = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
      if ($urandom_range(0, 7) == 0) ry = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
      apply(rx, ry, rz, ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7));
    end

    // Asynchronous reset while stalled with valid data held.
    apply(16'h1234, 16'h5678, 16'h9ABC, 1'b1, 1'b1);
    apply(16'h0F0F, 16'h0F0F, 16'h0F0F, 1'b1, 1'b0);
    check("pre_reset_valid", 48'(ov[0]), 48'd1);
    #2 rst = 1'b1;
    #1;
    check_zero("async_reset");
    for (int k = 0; k < int'(NI); k++) q[k].delete();
    iv = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_reset_in_ready", 48'(ir[0]), 48'd1);
    check_zero("post_reset");
    @(negedge clk);
    apply(16'h1000, 16'h0000, 16'h1000, 1'b1, 1'b1);
    check("post_reset_sample", {xo[0], yo[0], zo[0]}, {16'h1000, 16'h1000, 16'hF000});
    apply('0, '0, '0, 1'b0, 1'b1);
    apply('0, '0, '0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cordic_stage.md
Name: cordic_stage

Overview:
- One registered micro-rotation (iteration i = SHIFT) of the pipelined CORDIC datapath.
- N instances are chained with SHIFT = 0..N-1 to form the full rotator/vectorer.
- The x, y and z add/subtract paths are built from the team's 4-bit carry-lookahead adder slices.
- One pipeline register with valid/ready handshake decouples each stage from its neighbours.

Parameters:
- WIDTH, 16, datapath width of x, y, z in two's complement; must be a multiple of 4 (4-bit CLA slices).
- SHIFT, 0, iteration index i; arithmetic right-shift amount, 0..WIDTH-1.
- ANGLE, 16'h2000, atan(2^-i) in z units (16'h4000 = 90 degrees); WIDTH bits wide.
- MODE, 0, 0 = rotation (drive z to 0), 1 = vectoring (drive y to 0).

Ports:
- clk  input  1  stage clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream data valid
- in_ready  output  1  stage can accept data this cycle
- x_in  input  WIDTH  signed x
- y_in  input  WIDTH  signed y
- z_in  input  WIDTH  signed angle accumulator
- out_valid  output  1  registered result valid
- out_ready  input  1  downstream accepts result
- x_out  output  WIDTH  registered x'
- y_out  output  WIDTH  registered y'
- z_out  output  WIDTH  registered z'

Behaviour:
- Reset (async assert, released synchronously to clk): out_valid=0, x_out=y_out=z_out=0. in_ready=1 while reset is deasserted.
- Direction d:
  - MODE 0: d=+1 if z_in[WIDTH-1]=0, else d=-1.
  - MODE 1: d=+1 if y_in[WIDTH-1]=1, else d=-1.
- Datapath, from current inputs:
  - xs = x_in >>> SHIFT, ys = y_in >>> SHIFT (arithmetic, sign-filled).
  - x' = x_in - d*ys
  - y' = y_in + d*xs
  - z' = z_in - d*ANGLE
- Subtraction = add of the bitwise-inverted operand with carry_in=1.
- Each WIDTH-bit adder is WIDTH/4 cascaded 4-bit CLA slices, carry rippling between slices. The carry out of the MSB slice is discarded.
- All results wrap modulo 2^WIDTH. No saturation, no overflow flag.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational, one register deep, no skid).
  - Transfer in: in_valid && in_ready at a rising edge loads x'/y'/z' and sets out_valid=1.
  - Transfer out: out_valid && out_ready.
  - out_valid && out_ready && !in_valid: out_valid clears next cycle; data registers hold their last value.
  - Simultaneous transfer in and out: new data loads, out_valid stays 1, no bubble. Full throughput is 1 sample/cycle.
  - Stall (out_valid && !out_ready): x_out/y_out/z_out/out_valid are held bit-stable and in_ready=0. Upstream inputs are ignored even if in_valid=1.
- Latency: exactly 1 cycle from accepted input to out_valid when downstream is ready.
- Reset mid-operation: any held or in-flight sample is dropped and outputs return to 0. Nothing is replayed after release.
- SHIFT >= WIDTH-1: the shifted term equals the sign fill (0 or all-ones). This is legal and must not generate X.
- No combinational path from in_valid or data inputs to any output. The only combinational path is out_ready -> in_ready.

Test Plan:
- Rotation, SHIFT=0, ANGLE=16'h2000: x_in=16'h1000, y_in=0, z_in=16'h1000, in_valid=1, out_ready=1 -> next cycle out_valid=1, x_out=16'h1000, y_out=16'h1000, z_out=16'hF000.
- Rotation, SHIFT=2, negative z: x_in=16'h1000, y_in=16'h0400, z_in=16'hE000 -> x_out=16'h1100, y_out=16'h0000, z_out=16'h0000 (d=-1).
- Vectoring, MODE=1, SHIFT=0: x_in=16'h2000, y_in=16'hF000, z_in=0 -> x_out=16'h3000, y_out=16'h1000, z_out=16'hE000.
- Wrap: x_in=y_in=16'h7FFF, z_in=0, SHIFT=0 -> y_out=16'hFFFE, x_out=16'h0000; no X, no saturation.
- Backpressure:
  - Stimulus: stream 4 samples back-to-back with out_ready=1; hold out_ready=0 for 3 cycles mid-stream, then release.
  - Required: in_ready=0 during the stall and outputs bit-stable; no sample lost or duplicated; results in order; 1 sample/cycle when unstalled.
- Reset mid-op: assert rst asynchronously while out_valid=1 and stalled -> out_valid and data go to 0 immediately without a clock edge. After release, in_ready=1 and the next accepted sample emerges after 1 cycle.
